register_write_arbiter: RTL and testbench

//  Round-robin write-port arbiter for a shared enable/sync-reset register.

---
 rtl/register_write_arbiter_if.sv | 38 +++
 rtl/register_write_arbiter.sv | 127 ++++++++++++
 tb/tb_register_write_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/register_write_arbiter_if.sv
// Requester-side write bus and shared-register drive bus for register_write_arbiter.
// ARB_WRITE_LOCK_EN adds the per-requester req_lock signal.
interface register_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
`ifdef ARB_WRITE_LOCK_EN
  logic [NUM_REQ-1:0]       req_lock;
`endif
  logic [NUM_REQ-1:0]       req_ready;
  logic                     reg_en;
  logic [WIDTH-1:0]         reg_din;
  logic [IDW-1:0]           reg_gnt_id;

`ifdef ARB_WRITE_LOCK_EN
  modport master (
    output req_valid, req_data, req_lock,
    input  req_ready, reg_en, reg_din, reg_gnt_id
  );
  modport slave (
    input  req_valid, req_data, req_lock,
    output req_ready, reg_en, reg_din, reg_gnt_id
  );
`else
  modport master (
    output req_valid, req_data,
    input  req_ready, reg_en, reg_din, reg_gnt_id
  );
  modport slave (
    input  req_valid, req_data,
    output req_ready, reg_en, reg_din, reg_gnt_id
  );
`endif
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin write-port arbiter feeding one shared enable/sync-reset register.
// Grant is combinational; reg_en/reg_din/reg_gnt_id are registered one cycle
// after the handshake. Define ARB_WRITE_LOCK_EN to enable the grant-lock
// feature (req_lock port, LOCKED state).
module register_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
) (
  input  logic clk,
  input  logic rst,
  register_write_arbiter_if.slave bus
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef ARB_WRITE_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t         state, state_nxt;
  logic [IDW-1:0] owner, owner_nxt;
`endif

  logic [IDW-1:0]     ptr, ptr_nxt;
  logic               rr_any;
  logic [IDW-1:0]     rr_id;
  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;
  logic               hs;
  logic [NUM_REQ-1:0] ready;
  logic [WIDTH-1:0]   din_nxt;
  logic               reg_en_q;
  logic [WIDTH-1:0]   reg_din_q;
  logic [IDW-1:0]     reg_gnt_id_q;

  // Index following v, wrapping NUM_REQ-1 back to 0.
  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
    if (32'(v) == NUM_REQ - 1) return '0;
    return IDW'(32'(v) + 32'd1);
  endfunction

  // Round-robin search: first valid requester starting at ptr.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    rr_any = 1'b0;
    rr_id  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!rr_any && bus.req_valid[IDW'(idx)]) begin
        rr_any = 1'b1;
        rr_id  = IDW'(idx);
      end
    end
  end

  // Grant selection, handshake detection and next-state logic.
  always_comb begin
    ptr_nxt = ptr;
    gnt_any = rr_any;
    gnt_id  = rr_id;
`ifdef ARB_WRITE_LOCK_EN
    state_nxt = state;
    owner_nxt = owner;
    if (state == LOCKED) begin
      gnt_any = bus.req_valid[owner];
      gnt_id  = owner;
    end
`endif
    hs      = gnt_any && !rst;
    ready   = hs ? (NUM_REQ'(1) << gnt_id) : '0;
    din_nxt = bus.req_data[32'(gnt_id)*WIDTH +: WIDTH];
`ifdef ARB_WRITE_LOCK_EN
    case (state)
      ARB: begin
        if (hs) begin
          if (bus.req_lock[gnt_id]) begin
            state_nxt = LOCKED;
            owner_nxt = gnt_id;
          end else begin
            ptr_nxt = inc_wrap(gnt_id);
          end
        end
      end
      LOCKED: begin
        // Release on the first cycle the owner deasserts lock, beat or not.
        if (!bus.req_lock[owner]) begin
          state_nxt = ARB;
          ptr_nxt   = inc_wrap(owner);
        end
      end
      default: state_nxt = ARB;
    endcase
`else
    if (hs) ptr_nxt = inc_wrap(gnt_id);
`endif
  end

  // State, pointer and registered register-drive stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      reg_en_q     <= 1'b0;
      reg_din_q    <= '0;
      reg_gnt_id_q <= '0;
`ifdef ARB_WRITE_LOCK_EN
      state        <= ARB;
      owner        <= '0;
`endif
    end else begin
      ptr      <= ptr_nxt;
      reg_en_q <= hs;
      if (hs) begin
        reg_din_q    <= din_nxt;
        reg_gnt_id_q <= gnt_id;
      end
`ifdef ARB_WRITE_LOCK_EN
      state <= state_nxt;
      owner <= owner_nxt;
`endif
    end
  end

  assign bus.req_ready  = ready;
  assign bus.reg_en     = reg_en_q;
  assign bus.reg_din    = reg_din_q;
  assign bus.reg_gnt_id = reg_gnt_id_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed-vector bench for register_write_arbiter (NUM_REQ=4, WIDTH=32).
// Lock scenarios are compiled in when ARB_WRITE_LOCK_EN is defined.
module tb_register_write_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 32;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  register_write_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  register_write_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester i presents i*0x11.
  task automatic load_default_data();
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 32'(i * 32'h11);
  endtask

  task automatic set_lock(input logic [NUM_REQ-1:0] l);
`ifdef ARB_WRITE_LOCK_EN
    bus.req_lock = l;
`else
    if (l != '0) $display("note: lock request ignored in this build");
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    load_default_data();
    set_lock('0);
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ready got=%b exp=%b", bus.req_ready, 4'b0000);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (bus.reg_en !== 1'b0) begin
      miscompares++; $display("FAIL reset_reg_en got=%b exp=0", bus.reg_en);
    end
    vectors++;
    if (bus.reg_din !== 32'h0) begin
      miscompares++; $display("FAIL reset_reg_din got=%h exp=0", bus.reg_din);
    end
    vectors++;
    if (bus.reg_gnt_id !== 2'd0) begin
      miscompares++; $display("FAIL reset_gnt_id got=%0d exp=0", bus.reg_gnt_id);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL reset_first_grant got=%b exp=%b", bus.req_ready, 4'b0001);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [5];
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus.req_valid = 4'hF;
    for (int b = 0; b < 5; b++) begin
      #1;
      vectors++;
      if (bus.req_ready !== (4'b0001 << exp_id[b])) begin
        miscompares++; $display("FAIL rr_ready beat=%0d got=%b exp=%b", b, bus.req_ready, 4'b0001 << exp_id[b]);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.reg_en !== 1'b1 || bus.reg_gnt_id !== exp_id[b] || bus.reg_din !== 32'(exp_id[b] * 32'h11)) begin
        miscompares++;
        $display("FAIL rr_out beat=%0d got en=%b id=%0d din=%h exp en=1 id=%0d din=%h",
                 b, bus.reg_en, bus.reg_gnt_id, bus.reg_din, exp_id[b], 32'(exp_id[b] * 32'h11));
      end
    end
  endtask

  // Pointer is 1 on entry; the first beat moves it to 3 before the wrap check.
  task automatic test_wrap_skip();
    logic [3:0] vin   [4];
    logic [1:0] exp_id[4];
    vin    = '{4'b0100, 4'b0101, 4'b0101, 4'b1001};
    exp_id = '{2'd2,    2'd0,    2'd2,    2'd3};
    for (int b = 0; b < 4; b++) begin
      bus.req_valid = vin[b];
      #1;
      vectors++;
      if (bus.req_ready !== (4'b0001 << exp_id[b])) begin
        miscompares++; $display("FAIL wrap_ready beat=%0d got=%b exp=%b", b, bus.req_ready, 4'b0001 << exp_id[b]);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.reg_en !== 1'b1 || bus.reg_gnt_id !== exp_id[b] || bus.reg_din !== 32'(exp_id[b] * 32'h11)) begin
        miscompares++;
        $display("FAIL wrap_out beat=%0d got en=%b id=%0d din=%h exp id=%0d", b, bus.reg_en, bus.reg_gnt_id, bus.reg_din, exp_id[b]);
      end
    end
  endtask

  // Pointer is 0 on entry; reg_din=0x33, reg_gnt_id=3.
  task automatic test_idle();
    bus.req_valid = 4'b0000;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 32'hDEAD_0000 + 32'(i);
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (bus.req_ready !== 4'b0000) begin
        miscompares++; $display("FAIL idle_ready cyc=%0d got=%b exp=0000", c, bus.req_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.reg_en !== 1'b0 || bus.reg_din !== 32'h33 || bus.reg_gnt_id !== 2'd3) begin
        miscompares++;
        $display("FAIL idle_hold cyc=%0d got en=%b din=%h id=%0d exp en=0 din=00000033 id=3", c, bus.reg_en, bus.reg_din, bus.reg_gnt_id);
      end
    end
    load_default_data();
    bus.req_valid = 4'b0100;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0100) begin
      miscompares++; $display("FAIL idle_single_ready got=%b exp=0100", bus.req_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.reg_en !== 1'b1 || bus.reg_din !== 32'h22 || bus.reg_gnt_id !== 2'd2) begin
      miscompares++; $display("FAIL idle_single_out got en=%b din=%h id=%0d exp en=1 din=00000022 id=2", bus.reg_en, bus.reg_din, bus.reg_gnt_id);
    end
    bus.req_valid = 4'hF;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b1000) begin
      miscompares++; $display("FAIL idle_ptr_ready got=%b exp=1000", bus.req_ready);
    end
    @(posedge clk); #1;
  endtask

`ifdef ARB_WRITE_LOCK_EN
  // Pointer is 0 on entry.
  task automatic test_lock();
    bus.req_valid = 4'b0001;
    set_lock('0);
    @(posedge clk); #1;
    bus.req_valid = 4'b0111;
    set_lock(4'b0010);
    for (int b = 0; b < 3; b++) begin
      #1;
      vectors++;
      if (bus.req_ready !== 4'b0010) begin
        miscompares++; $display("FAIL lock_ready beat=%0d got=%b exp=0010", b, bus.req_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.reg_en !== 1'b1 || bus.reg_gnt_id !== 2'd1 || bus.reg_din !== 32'h11) begin
        miscompares++; $display("FAIL lock_out beat=%0d got en=%b id=%0d din=%h exp id=1", b, bus.reg_en, bus.reg_gnt_id, bus.reg_din);
      end
    end
    bus.req_valid = 4'b0101;
    set_lock('0);
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL lock_release_ready got=%b exp=0000", bus.req_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.reg_en !== 1'b0) begin
      miscompares++; $display("FAIL lock_release_en got=%b exp=0", bus.reg_en);
    end
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0100) begin
      miscompares++; $display("FAIL lock_after_ready got=%b exp=0100", bus.req_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.reg_en !== 1'b1 || bus.reg_gnt_id !== 2'd2) begin
      miscompares++; $display("FAIL lock_after_out got en=%b id=%0d exp en=1 id=2", bus.reg_en, bus.reg_gnt_id);
    end
  endtask
`endif

  task automatic test_reset_mid();
`ifdef ARB_WRITE_LOCK_EN
    // Pointer is 3: requester 1 locks, then others must be held off.
    bus.req_valid = 4'b0010;
    set_lock(4'b0010);
    @(posedge clk); #1;
    bus.req_valid = 4'b0111;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0010) begin
      miscompares++; $display("FAIL mid_locked_ready got=%b exp=0010", bus.req_ready);
    end
`else
    bus.req_valid = 4'hF;
    #1;
`endif
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL mid_rst_ready got=%b exp=0000", bus.req_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.reg_en !== 1'b0 || bus.reg_din !== 32'h0 || bus.reg_gnt_id !== 2'd0) begin
      miscompares++; $display("FAIL mid_rst_out got en=%b din=%h id=%0d exp en=0 din=0 id=0", bus.reg_en, bus.reg_din, bus.reg_gnt_id);
    end
    rst = 1'b0;
    set_lock('0);
    bus.req_valid = 4'b0110;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0010) begin
      miscompares++; $display("FAIL mid_post_ready got=%b exp=0010", bus.req_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.reg_en !== 1'b1 || bus.reg_gnt_id !== 2'd1 || bus.reg_din !== 32'h11) begin
      miscompares++; $display("FAIL mid_post_out got en=%b id=%0d din=%h exp en=1 id=1 din=00000011", bus.reg_en, bus.reg_gnt_id, bus.reg_din);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_wrap_skip();
    test_idle();
`ifdef ARB_WRITE_LOCK_EN
    test_lock();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
